// File: rtl/lockstep_scoreboard_if.sv
// Record bus carrying one ideal-model and one DUV memory-side record per cycle.
// The harness drives it through master; the scoreboard observes it through slave.
interface lockstep_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int NCH    = 4
);
  logic                  ideal_valid;
  logic [NCH*DATA_W-1:0] ideal_data;
  logic [1:0]            ideal_ctrl;
  logic                  duv_valid;
  logic [NCH*DATA_W-1:0] duv_data;
  logic [1:0]            duv_ctrl;

  modport master (
    output ideal_valid, ideal_data, ideal_ctrl,
    output duv_valid, duv_data, duv_ctrl
  );

  modport slave (
    input ideal_valid, ideal_data, ideal_ctrl,
    input duv_valid, duv_data, duv_ctrl
  );
endinterface

// File: rtl/lockstep_scoreboard.sv
// Lockstep comparator: ideal records are buffered in a FIFO and each DUV record is checked against the oldest one.
// Define LOCKSTEP_FIRST_CAPTURE_EN to build the first-failure capture registers (first_duv / first_ideal).
module lockstep_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int NCH     = 4,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int MAX_ERR = 8
) (
  input  logic                         CLK,
  input  logic                         RSTa,
  input  logic                         en,
  input  logic                         clear,
  input  logic [NCH:0]                 ch_mask,
  lockstep_scoreboard_if.slave         rec,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [CNT_W-1:0]             err_cnt,
  output logic                         mismatch,
  output logic [NCH:0]                 mismatch_ch,
  output logic                         sticky_err,
  output logic                         overflow,
  output logic                         underflow,
  output logic [1:0]                   state,
  output logic [NCH*DATA_W+1:0]        first_duv,
  output logic [NCH*DATA_W+1:0]        first_ideal
);
  localparam int REC_W = NCH*DATA_W + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] ERR_LIM  = CNT_W'(MAX_ERR);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t           state_q;
  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [REC_W-1:0] ideal_rec, duv_rec, ref_rec;
  logic             run, fifo_empty, fifo_full;
  logic             bypass, do_pop, do_push, do_cmp, drop, starve, fail, halt_hit;
  logic [NCH:0]     diff;
  logic [CNT_W-1:0] err_sat;

  assign ideal_rec  = {rec.ideal_ctrl, rec.ideal_data};
  assign duv_rec    = {rec.duv_ctrl, rec.duv_data};
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_FULL);
  assign run        = (state_q == RUN) && en;

  // An empty FIFO lets a same-cycle ideal record feed the compare directly.
  assign bypass  = run && fifo_empty && rec.ideal_valid && rec.duv_valid;
  assign do_pop  = run && rec.duv_valid && !fifo_empty;
  assign do_cmp  = bypass || do_pop;
  assign starve  = run && rec.duv_valid && fifo_empty && !rec.ideal_valid;
  assign do_push = run && rec.ideal_valid && !bypass && (!fifo_full || do_pop);
  assign drop    = run && rec.ideal_valid && fifo_full && !do_pop;
  assign ref_rec = fifo_empty ? ideal_rec : mem[rd_ptr];

  always_comb begin
    diff = '0;
    for (int k = 0; k < NCH; k++)
      diff[k] = ch_mask[k] && (ref_rec[k*DATA_W +: DATA_W] != duv_rec[k*DATA_W +: DATA_W]);
    diff[NCH] = ch_mask[NCH] && (ref_rec[REC_W-1 -: 2] != duv_rec[REC_W-1 -: 2]);
  end

  assign fail     = do_cmp && (|diff);
  assign err_sat  = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + 1'b1;
  assign halt_hit = fail && (MAX_ERR != 0) && (err_sat == ERR_LIM);

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= ideal_rec;
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q     <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      match_cnt   <= '0;
      err_cnt     <= '0;
      mismatch    <= 1'b0;
      mismatch_ch <= '0;
      sticky_err  <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      match_cnt   <= '0;
      err_cnt     <= '0;
      mismatch    <= 1'b0;
      mismatch_ch <= '0;
      sticky_err  <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (state_q)
        IDLE: if (en) state_q <= RUN;
        RUN: begin
          if (!en) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
          end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      fifo_level <= fifo_level + 1'b1;
            else if (do_pop && !do_push) fifo_level <= fifo_level - 1'b1;
            if (drop)   overflow  <= 1'b1;
            if (starve) underflow <= 1'b1;
            if (do_cmp && !fail && match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
            if (fail) begin
              err_cnt     <= err_sat;
              mismatch    <= 1'b1;
              mismatch_ch <= diff;
              sticky_err  <= 1'b1;
              if (halt_hit) state_q <= HALT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

`ifdef LOCKSTEP_FIRST_CAPTURE_EN
  // Only the first failure since reset/clear is kept; sticky_err marks that it happened.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      first_duv   <= '0;
      first_ideal <= '0;
    end else if (clear) begin
      first_duv   <= '0;
      first_ideal <= '0;
    end else if (fail && !sticky_err) begin
      first_duv   <= duv_rec;
      first_ideal <= ref_rec;
    end
  end
`else
  assign first_duv   = '0;
  assign first_ideal = '0;
`endif
endmodule

// File: tb/tb_lockstep_scoreboard.sv
// Randomized bench for lockstep_scoreboard, checked every cycle against a queue-based model.
// Directed scenarios pin the model with hand-computed values before the random run.
module tb_lockstep_scoreboard;
  localparam int DATA_W  = 32;
  localparam int NCH     = 4;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;
  localparam int MAX_ERR = 2;
  localparam int REC_W   = NCH*DATA_W + 2;
  localparam int LVL_W   = $clog2(DEPTH+1);

  typedef logic [REC_W-1:0] rec_t;

  logic              CLK = 1'b0;
  logic              RSTa = 1'b0;
  logic              en = 1'b0;
  logic              clear = 1'b0;
  logic [NCH:0]      ch_mask = '1;
  logic [LVL_W-1:0]  fifo_level;
  logic [CNT_W-1:0]  match_cnt, err_cnt;
  logic              mismatch, sticky_err, overflow, underflow;
  logic [NCH:0]      mismatch_ch;
  logic [1:0]        state;
  logic [REC_W-1:0]  first_duv, first_ideal;

  int tests = 0;
  int failed = 0;
  bit checkEn = 0;

  lockstep_scoreboard_if #(.DATA_W(DATA_W), .NCH(NCH)) rec_if ();

  lockstep_scoreboard #(
    .DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_ERR(MAX_ERR)
  ) dut (
    .CLK(CLK), .RSTa(RSTa), .en(en), .clear(clear), .ch_mask(ch_mask), .rec(rec_if),
    .fifo_level(fifo_level), .match_cnt(match_cnt), .err_cnt(err_cnt),
    .mismatch(mismatch), .mismatch_ch(mismatch_ch), .sticky_err(sticky_err),
    .overflow(overflow), .underflow(underflow), .state(state),
    .first_duv(first_duv), .first_ideal(first_ideal)
  );

  always #5 CLK = ~CLK;

  // Reference model: a queue of pending ideal records plus plain counters and flags.
  rec_t mq[$];
  int   mState = 0;
  int   mMatch = 0, mErr = 0;
  bit   mMis = 0, mSticky = 0, mOver = 0, mUnder = 0;
  logic [NCH:0] mMisCh = '0;
  rec_t mFirstD = '0, mFirstI = '0;
  rec_t mInc, mDuv;
  bit   mUsed;

  function automatic logic [31:0] chanOf(rec_t r, int k);
    if (k == NCH) return 32'(r[REC_W-1 -: 2]);
    return r[k*DATA_W +: DATA_W];
  endfunction

  task automatic modelReset();
    mq.delete();
    mState = 0; mMatch = 0; mErr = 0;
    mMis = 0; mSticky = 0; mOver = 0; mUnder = 0;
    mMisCh = '0; mFirstD = '0; mFirstI = '0;
  endtask

  task automatic modelCompare(input rec_t refRec, input rec_t duvRec);
    logic [NCH:0] d;
    for (int k = 0; k <= NCH; k++) d[k] = ch_mask[k] && (chanOf(refRec, k) != chanOf(duvRec, k));
    if (d == '0) begin
      if (mMatch < (1 << CNT_W) - 1) mMatch++;
    end else begin
      if (mErr < (1 << CNT_W) - 1) mErr++;
      mMis = 1;
      mMisCh = d;
`ifdef LOCKSTEP_FIRST_CAPTURE_EN
      if (!mSticky) begin
        mFirstD = duvRec;
        mFirstI = refRec;
      end
`endif
      mSticky = 1;
      if (MAX_ERR != 0 && mErr == MAX_ERR) mState = 2;
    end
  endtask

  always @(posedge CLK or negedge RSTa) begin
    if (!RSTa || clear) modelReset();
    else begin
      mMis = 0;
      if (mState == 0) begin
        if (en) mState = 1;
      end else if (mState == 1) begin
        if (!en) begin
          mq.delete();
          mState = 0;
        end else begin
          mInc  = {rec_if.ideal_ctrl, rec_if.ideal_data};
          mDuv  = {rec_if.duv_ctrl, rec_if.duv_data};
          mUsed = 0;
          if (rec_if.duv_valid) begin
            if (mq.size() > 0) modelCompare(mq.pop_front(), mDuv);
            else if (rec_if.ideal_valid) begin
              modelCompare(mInc, mDuv);
              mUsed = 1;
            end else mUnder = 1;
          end
          if (rec_if.ideal_valid && !mUsed) begin
            if (mq.size() < DEPTH) mq.push_back(mInc);
            else mOver = 1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle all outputs are compared against the model, away from the active edge.
  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("m.fifo_level", 256'(fifo_level), 256'(mq.size()));
      checkOutput("m.match_cnt", 256'(match_cnt), 256'(mMatch));
      checkOutput("m.err_cnt", 256'(err_cnt), 256'(mErr));
      checkOutput("m.mismatch", 256'(mismatch), 256'(mMis));
      checkOutput("m.mismatch_ch", 256'(mismatch_ch), 256'(mMisCh));
      checkOutput("m.sticky_err", 256'(sticky_err), 256'(mSticky));
      checkOutput("m.overflow", 256'(overflow), 256'(mOver));
      checkOutput("m.underflow", 256'(underflow), 256'(mUnder));
      checkOutput("m.state", 256'(state), 256'(mState));
      checkOutput("m.first_duv", 256'(first_duv), 256'(mFirstD));
      checkOutput("m.first_ideal", 256'(first_ideal), 256'(mFirstI));
    end
  end

  function automatic rec_t randRec();
    rec_t r;
    for (int k = 0; k < NCH; k++) r[k*DATA_W +: DATA_W] = $urandom;
    r[REC_W-1 -: 2] = 2'($urandom);
    return r;
  endfunction

  // Drives one cycle of records, then returns just after the edge that sampled them.
  task automatic applyStimulus(input bit iv, input rec_t ir, input bit dv, input rec_t dr);
    rec_if.ideal_valid = iv;
    rec_if.ideal_data  = ir[NCH*DATA_W-1:0];
    rec_if.ideal_ctrl  = ir[REC_W-1 -: 2];
    rec_if.duv_valid   = dv;
    rec_if.duv_data    = dr[NCH*DATA_W-1:0];
    rec_if.duv_ctrl    = dr[REC_W-1 -: 2];
    @(posedge CLK);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
  endtask

  task automatic clearAndStart(input logic [NCH:0] mask);
    ch_mask = mask;
    clear = 1'b1; en = 1'b0;
    idleCycle();
    clear = 1'b0; en = 1'b1;
    idleCycle();
  endtask

  task automatic skewScenario(input logic [NCH:0] mask);
    rec_t r [3];
    rec_t bad;
    clearAndStart(mask);
    for (int i = 0; i < 3; i++) begin
      r[i] = randRec();
      r[i][2*DATA_W +: DATA_W] = 32'h0;
      applyStimulus(1'b1, r[i], 1'b0, '0);
    end
    checkOutput("skew.level", 256'(fifo_level), 256'(3));
    applyStimulus(1'b0, '0, 1'b1, r[0]);
    bad = r[1];
    bad[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    applyStimulus(1'b0, '0, 1'b1, bad);
    if (mask[2]) begin
      checkOutput("skew.mismatch", 256'(mismatch), 256'(1));
      checkOutput("skew.mismatch_ch", 256'(mismatch_ch), 256'(5'b00100));
    end
    applyStimulus(1'b0, '0, 1'b1, r[2]);
    checkOutput("skew.pulse_end", 256'(mismatch), 256'(0));
  endtask

  initial begin
    rec_t r, d;
    rec_t pend[$];
    bit iv, dv;

    idleCycle();
    idleCycle();
    checkEn = 1;
    RSTa = 1'b1;
    idleCycle();

    checkOutput("reset.state", 256'(state), 256'(0));
    checkOutput("reset.level", 256'(fifo_level), 256'(0));
    checkOutput("reset.match", 256'(match_cnt), 256'(0));
    checkOutput("reset.first_duv", 256'(first_duv), 256'(0));

    // Lockstep through the bypass path.
    en = 1'b1;
    idleCycle();
    for (int i = 0; i < 10; i++) begin
      r = randRec();
      applyStimulus(1'b1, r, 1'b1, r);
    end
    idleCycle();
    checkOutput("lockstep.match", 256'(match_cnt), 256'(10));
    checkOutput("lockstep.err", 256'(err_cnt), 256'(0));
    checkOutput("lockstep.level", 256'(fifo_level), 256'(0));

    skewScenario('1);
    checkOutput("skew.match", 256'(match_cnt), 256'(2));
    checkOutput("skew.err", 256'(err_cnt), 256'(1));
    checkOutput("skew.mismatch_ch_hold", 256'(mismatch_ch), 256'(5'b00100));
`ifdef LOCKSTEP_FIRST_CAPTURE_EN
    checkOutput("skew.first_duv_ch2", 256'(first_duv[2*DATA_W +: DATA_W]), 256'(32'hDEAD_BEEF));
    checkOutput("skew.first_ideal_ch2", 256'(first_ideal[2*DATA_W +: DATA_W]), 256'(0));
`else
    checkOutput("skew.first_duv_off", 256'(first_duv), 256'(0));
`endif

    skewScenario(5'b11011);
    checkOutput("mask.err", 256'(err_cnt), 256'(0));
    checkOutput("mask.match", 256'(match_cnt), 256'(3));

    // Overflow, then underflow after clear.
    clearAndStart('1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, randRec(), 1'b0, '0);
    checkOutput("ovf.level", 256'(fifo_level), 256'(8));
    checkOutput("ovf.flag", 256'(overflow), 256'(1));
    clearAndStart('1);
    applyStimulus(1'b0, '0, 1'b1, randRec());
    checkOutput("udf.flag", 256'(underflow), 256'(1));
    checkOutput("udf.match", 256'(match_cnt), 256'(0));
    checkOutput("udf.err", 256'(err_cnt), 256'(0));

    // HALT after MAX_ERR failures.
    clearAndStart('1);
    r = '0; r[31:0] = 32'd1;
    d = '0; d[31:0] = 32'd2;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, r, 1'b1, d);
    checkOutput("halt.err", 256'(err_cnt), 256'(2));
    checkOutput("halt.state", 256'(state), 256'(2));
    checkOutput("halt.third_ignored", 256'(mismatch), 256'(0));
    clear = 1'b1;
    idleCycle();
    clear = 1'b0;
    checkOutput("halt.clear_state", 256'(state), 256'(0));
    checkOutput("halt.clear_err", 256'(err_cnt), 256'(0));

    // Reset mid-run with records buffered.
    clearAndStart('1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, randRec(), 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, d);
    checkOutput("rst.level_before", 256'(fifo_level), 256'(3));
    en = 1'b0;
    RSTa = 1'b0;
    idleCycle();
    RSTa = 1'b1;
    checkOutput("rst.level", 256'(fifo_level), 256'(0));
    checkOutput("rst.state", 256'(state), 256'(0));
    checkOutput("rst.flags", 256'({sticky_err, overflow, underflow, mismatch}), 256'(0));
    checkOutput("rst.counts", 256'({match_cnt, err_cnt}), 256'(0));

    // Randomized traffic: the DUV mostly replays the ideal stream, with rare corruption.
    for (int c = 0; c < 1500; c++) begin
      clear = ($urandom_range(0, 39) == 0);
      en = ($urandom_range(0, 59) != 0);
      ch_mask = ($urandom_range(0, 3) == 0) ? 5'($urandom) : '1;
      iv = 0; dv = 0; r = '0; d = '0;
      if (clear) pend.delete();
      else begin
        if ($urandom_range(0, 2) != 0) begin
          iv = 1;
          r = randRec();
          pend.push_back(r);
        end
        if (pend.size() > 0 && $urandom_range(0, 99) < ((pend.size() > 5) ? 90 : 55)) begin
          dv = 1;
          d = pend.pop_front();
          if ($urandom_range(0, 15) == 0) d[$urandom_range(0, REC_W-1)] ^= 1'b1;
        end else if ($urandom_range(0, 29) == 0) begin
          dv = 1;
          d = randRec();
        end
      end
      applyStimulus(iv, r, dv, d);
    end
    clear = 1'b0;
    idleCycle();
    @(negedge CLK);
    #1;
    checkEn = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
